// File: rtl/s00_axi_lite_regs.sv
// AXI4-Lite slave holding four 32-bit registers. Registers are exported to
// user logic along with a one-cycle write pulse per register. All responses
// are OKAY.
module s00_axi_lite_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] RESET_VALUE        = 32'h0000_0000
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [127:0]                    reg_out,
    output logic [3:0]                      wr_pulse
);

    // Byte-wise merge: a cleared strobe bit keeps the old byte.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic              ready_en_q, ready_en_d;
    logic              aw_held_q,  aw_held_d;
    logic [1:0]        aw_sel_q,   aw_sel_d;
    logic              w_held_q,   w_held_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [3:0]        wstrb_q,    wstrb_d;
    logic              bvalid_q,   bvalid_d;
    logic              rvalid_q,   rvalid_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic [3:0][31:0]  regs_q,     regs_d;
    logic [3:0]        wr_pulse_q, wr_pulse_d;

    logic awready_s, wready_s, arready_s;
    logic aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic unused_s;

    // Protection bits and byte-offset/alias address bits carry no meaning here.
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign awready_s = ready_en_q & ~aw_held_q & ~bvalid_q;
    assign wready_s  = ready_en_q & ~w_held_q  & ~bvalid_q;
    assign arready_s = ready_en_q & ~rvalid_q;
    assign aw_hs_s   = S_AXI_AWVALID & awready_s;
    assign w_hs_s    = S_AXI_WVALID  & wready_s;
    assign ar_hs_s   = S_AXI_ARVALID & arready_s;
    assign commit_s  = aw_held_q & w_held_q;

    assign S_AXI_AWREADY = awready_s;
    assign S_AXI_WREADY  = wready_s;
    assign S_AXI_ARREADY = arready_s;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_out       = regs_q;
    assign wr_pulse      = wr_pulse_q;

    // Next-state: write capture/commit, write response, and read response.
    always_comb begin
        ready_en_d = 1'b1;
        aw_held_d  = aw_held_q;
        aw_sel_d   = aw_sel_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        regs_d     = regs_q;
        wr_pulse_d = 4'b0000;

        // Address and data are parked independently until both are present.
        if (commit_s) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_held_d = 1'b1;
                aw_sel_d  = S_AXI_AWADDR[3:2];
            end else begin
                aw_held_d = aw_held_q;
            end
            if (w_hs_s) begin
                w_held_d = 1'b1;
                wdata_d  = S_AXI_WDATA;
                wstrb_d  = S_AXI_WSTRB;
            end else begin
                w_held_d = w_held_q;
            end
        end

        // Commit the parked write; response stays up until accepted.
        if (commit_s) begin
            regs_d[aw_sel_q] = merge_bytes(regs_q[aw_sel_q], wdata_q, wstrb_q);
            wr_pulse_d       = 4'b0001 << aw_sel_q;
            bvalid_d         = 1'b1;
        end else if (bvalid_q & S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        // Read samples the pre-commit register value on a same-edge collision.
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
        end else if (rvalid_q & S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // State registers; reset aborts any transfer in flight.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_sel_q   <= 2'b00;
            w_held_q   <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            wstrb_q    <= 4'b0000;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            regs_q     <= {4{RESET_VALUE}};
            wr_pulse_q <= 4'b0000;
        end else begin
            ready_en_q <= ready_en_d;
            aw_held_q  <= aw_held_d;
            aw_sel_q   <= aw_sel_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

endmodule

// File: tb/tb_s00_axi_lite_regs.sv
// Self-checking bench for s00_axi_lite_regs: directed scenarios followed by
// randomized write/read traffic compared against a register-array model.
module tb_s00_axi_lite_regs;

    logic         clk;
    logic         ARESETN;
    logic [3:0]   AWADDR;
    logic [2:0]   AWPROT;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [3:0]   ARADDR;
    logic [2:0]   ARPROT;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] model [4];
    int pulse_cnt [4] = '{0, 0, 0, 0};

    s00_axi_lite_regs dut (
        .ACLK(clk), .ARESETN(ARESETN),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID),
        .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID),
        .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID),
        .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID),
        .S_AXI_RREADY(RREADY),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write pulses per register, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_pulse[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
        end
    end

    // Absolute time limit in case a wait is not bounded somewhere.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model_vec();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int sel = int'(addr[3:2]);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[sel][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // Issue one write with independent AW/W delays; returns with BVALID up.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_now, w_now;
        int cyc = 0;
        logic [3:0] exp_pulse;
        AWADDR = addr;
        WDATA  = data;
        WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (!aw_done && cyc >= aw_dly) AWVALID = 1'b1;
            if (!w_done && cyc >= w_dly) WVALID = 1'b1;
            if (aw_done && !w_done) check("awready_after_capture", AWREADY, 1'b0);
            if (w_done && !aw_done) check("wready_after_capture", WREADY, 1'b0);
            aw_now = AWVALID && AWREADY;
            w_now  = WVALID && WREADY;
            step();
            if (aw_now) begin aw_done = 1'b1; AWVALID = 1'b0; end
            if (w_now)  begin w_done  = 1'b1; WVALID  = 1'b0; end
            cyc++;
        end
        check("write_hs_timeout", {aw_done, w_done}, 2'b11);
        check("bvalid_before_commit", BVALID, 1'b0);
        step();
        check("bvalid_at_commit", BVALID, 1'b1);
        check("bresp", BRESP, 2'b00);
        exp_pulse = 4'b0001 << addr[3:2];
        check("wr_pulse", wr_pulse, exp_pulse);
        model_write(addr, data, strb);
        check("reg_out_after_write", reg_out, model_vec());
    endtask

    // Hold BREADY low for dly cycles, then accept the response.
    task automatic b_accept(input int dly);
        for (int i = 0; i < dly; i++) begin
            check("bvalid_hold", BVALID, 1'b1);
            check("awready_blocked", AWREADY, 1'b0);
            check("wready_blocked", WREADY, 1'b0);
            step();
        end
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check("bvalid_drop", BVALID, 1'b0);
        check("wr_pulse_idle", wr_pulse, 4'b0000);
    endtask

    // Read one register, holding RREADY low for dly cycles.
    task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input int dly);
        bit hs = 1'b0;
        bit ar_now;
        int cyc = 0;
        ARADDR  = addr;
        ARVALID = 1'b1;
        while (!hs && cyc < 50) begin
            ar_now = ARVALID && ARREADY;
            step();
            if (ar_now) hs = 1'b1;
            cyc++;
        end
        ARVALID = 1'b0;
        check("read_hs_timeout", hs, 1'b1);
        check("rvalid_up", RVALID, 1'b1);
        check("rdata", RDATA, exp);
        check("rresp", RRESP, 2'b00);
        for (int i = 0; i < dly; i++) begin
            step();
            check("rvalid_hold", RVALID, 1'b1);
            check("rdata_hold", RDATA, exp);
        end
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        check("rvalid_drop", RVALID, 1'b0);
    endtask

    initial begin
        logic [31:0] old_val;
        logic [31:0] tdata [4];
        logic [3:0]  raddr;
        tdata[0] = 32'h0101FFFF; tdata[1] = 32'hABCD0001;
        tdata[2] = 32'hDEAD0011; tdata[3] = 32'hBEEF0011;
        for (int i = 0; i < 4; i++) model[i] = 32'h0000_0000;
        ARESETN = 1'b0;
        AWADDR = 4'h0; AWPROT = 3'b000; AWVALID = 1'b0;
        WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = 4'h0; ARPROT = 3'b000; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_awready", AWREADY, 1'b0);
        check("rst_wready", WREADY, 1'b0);
        check("rst_arready", ARREADY, 1'b0);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_wr_pulse", wr_pulse, 4'b0000);
        check("rst_reg_out", reg_out, model_vec());
        ARESETN = 1'b1;
        check("ready_gated_after_release", AWREADY, 1'b0);
        step();
        check("awready_en", AWREADY, 1'b1);
        check("wready_en", WREADY, 1'b1);
        check("arready_en", ARREADY, 1'b1);

        // 1: write/read each register
        for (int i = 0; i < 4; i++) begin
            do_write(4'(i * 4), tdata[i], 4'hF, 0, 0);
            b_accept(0);
            do_read(4'(i * 4), tdata[i], 0);
        end
        for (int i = 0; i < 4; i++) check("pulse_once", 32'(pulse_cnt[i]), 32'd1);

        // 2: AW before W, then W before AW
        do_write(4'h4, 32'h1357_9BDF, 4'hF, 0, 3);
        b_accept(0);
        do_write(4'h8, 32'h2468_ACE0, 4'hF, 3, 0);
        b_accept(0);
        do_read(4'h4, model[1], 0);
        do_read(4'h8, model[2], 0);

        // 3: partial strobes
        do_write(4'h0, 32'hFFFF_FFFF, 4'hF, 0, 0);
        b_accept(0);
        do_write(4'h0, 32'h1234_5678, 4'b0101, 1, 0);
        b_accept(0);
        do_read(4'h0, 32'hFF34_FF78, 0);

        // 4: stalled B with concurrent read of reg2
        do_write(4'h8, 32'hCAFE_F00D, 4'hF, 0, 0);
        do_read(4'h8, model[2], 0);
        b_accept(5);

        // 5: commit and AR to the same register on one edge
        old_val = model[3];
        AWADDR = 4'hC; WDATA = 32'h5A5A_C3C3; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        check("coll_awready", AWREADY, 1'b1);
        check("coll_wready", WREADY, 1'b1);
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 4'hC; ARVALID = 1'b1;
        check("coll_arready", ARREADY, 1'b1);
        step();
        ARVALID = 1'b0;
        check("coll_bvalid", BVALID, 1'b1);
        check("coll_rvalid", RVALID, 1'b1);
        check("coll_rdata_old", RDATA, old_val);
        model_write(4'hC, 32'h5A5A_C3C3, 4'hF);
        check("coll_reg_out", reg_out, model_vec());
        for (int i = 0; i < 4; i++) begin
            step();
            check("coll_rdata_stable", RDATA, old_val);
        end
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        check("coll_rvalid_drop", RVALID, 1'b0);
        b_accept(0);
        do_read(4'hC, model[3], 0);

        // 6: reset between AW and W
        AWADDR = 4'h4; AWVALID = 1'b1;
        check("abort_awready", AWREADY, 1'b1);
        step();
        AWVALID = 1'b0;
        ARESETN = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) model[i] = 32'h0000_0000;
        check("abort_awready0", AWREADY, 1'b0);
        check("abort_wready0", WREADY, 1'b0);
        check("abort_arready0", ARREADY, 1'b0);
        check("abort_bvalid0", BVALID, 1'b0);
        check("abort_rdata0", RDATA, 32'h0);
        check("abort_regs", reg_out, model_vec());
        step();
        ARESETN = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            check("abort_no_bvalid", BVALID, 1'b0);
            step();
        end
        for (int i = 0; i < 4; i++) do_read(4'(i * 4), model[i], 0);

        // Randomized traffic against the model
        for (int n = 0; n < 24; n++) begin
            do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            b_accept(int'($urandom_range(0, 2)));
            raddr = 4'($urandom_range(0, 15));
            do_read(raddr, model[raddr[3:2]], int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/s00_axi_lite_regs.md
Name: s00_axi_lite_regs

Overview:
AXI4-Lite slave register file for the S00_AXI interface. It holds four 32-bit software-visible registers, driven by the AXI4-Lite master BFM in simulation and by the PS in hardware. It exports the register contents and per-register write pulses to downstream user logic. All responses are OKAY.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.
RESET_VALUE, 32'h0000_0000, reset value of all four registers.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESETN  in  1  asynchronous active-low reset; deassertion is synchronous to ACLK upstream.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  always 2'b00.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  always 2'b00.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
reg_out  out  128  {reg3,reg2,reg1,reg0}.
wr_pulse  out  4  one-cycle pulse, bit n set on the edge reg n is written.

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - All READY and VALID outputs are 0; RDATA is 0; wr_pulse is 0.
  - All registers load RESET_VALUE.
  - The aw_held and w_held flags clear.
  - A registered ready_en flag clears; it sets on the first edge after release.
- All READY outputs are gated by ready_en, so they are first high one cycle after reset release.
- Write channel:
  - AWREADY = ready_en & !aw_held & !BVALID. WREADY = ready_en & !w_held & !BVALID.
  - The AW handshake captures AWADDR[3:2] and sets aw_held. The W handshake captures WDATA/WSTRB and sets w_held. AW and W may arrive in either order, the same cycle, or any number of cycles apart.
  - Commit happens on the first edge where aw_held & w_held = 1:
    - the selected register updates byte-wise per WSTRB (strobe 0 keeps the old byte);
    - wr_pulse[sel] is 1 for exactly that cycle;
    - BVALID rises;
    - both held flags clear.
  - Minimum latency: handshake at edge N, commit and BVALID at edge N+1.
  - BVALID stays high until BVALID & BREADY. No new AW or W is accepted while BVALID=1. At most one write is outstanding.
  - WSTRB=0 still commits, fires wr_pulse, and responds OKAY, with no data change.
- Read channel:
  - ARREADY = ready_en & !RVALID.
  - On the AR handshake at edge N, RDATA is loaded with the register selected by ARADDR[3:2] and RVALID rises at edge N.
  - RDATA and RVALID are held stable until RVALID & RREADY; RVALID falls on that edge.
  - Read throughput is one transfer per 2 cycles.
- Read/write collision: if an AR handshake and a commit to the same register occur on the same edge, the read returns the pre-write value. The write is visible to any later AR.
- Address decoding:
  - Address bits above [3:2] are ignored; the four registers alias across the space.
  - Bits [1:0] are ignored.
  - No SLVERR or DECERR is ever generated.
- Reset asserted mid-transaction aborts everything immediately:
  - held flags, BVALID, and RVALID clear;
  - registers return to RESET_VALUE;
  - no response is issued for the aborted transfer.
- Read and write channels are fully independent. A pending BVALID never blocks reads, and vice versa.

Test Plan:
1. Release reset, then four write/read pairs to base+0x0, 0x4, 0x8, 0xC with data 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011, WSTRB=4'hF → every BRESP/RRESP is 2'b00, read data equals written data, and wr_pulse fires bits 0, 1, 2, 3 once each.
2. AWVALID 3 cycles before WVALID to 0x4, then the reverse order to 0x8 → AWREADY drops after capture, commit occurs one edge after the second handshake, and the registers hold the correct data.
3. Write 0xFFFFFFFF to reg0, then write 0x12345678 with WSTRB=4'b0101 → reg0 reads back 0xFF34FF78.
4. BREADY held low for 5 cycles after a write → BVALID stays high, AWREADY/WREADY stay low, and a concurrent read of reg2 completes normally. BVALID drops on the BREADY edge.
5. Write to 0xC commits on the same edge as an AR to 0xC → the read returns the old value and an immediate re-read returns the new value. RREADY held low for 4 cycles keeps RDATA stable.
6. ARESETN pulsed low after the AW handshake but before W → outputs go to 0 immediately, registers read back RESET_VALUE, and no BVALID appears afterwards.
